// File: rtl/tinyfpga_cfg_loader.sv
// tinyfpga_cfg_loader: host-side writer for the tinyFPGA configuration scan
// chain. Accepts bitstream bytes over valid/ready and shifts them MSB first
// onto prog_in with prog_en high for exactly CHAIN_LEN bits.
// Optional macro TINYFPGA_CFG_READBACK_EN adds rb_crc, a CRC-16-CCITT of the
// old chain contents observed on prog_out while shifting.
module tinyfpga_cfg_loader #(
  parameter int unsigned CHAIN_LEN = 144,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             prog_en,
  output logic             prog_in,
  input  logic             prog_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_count
`ifdef TINYFPGA_CFG_READBACK_EN
  ,
  output logic [15:0]      rb_crc
`endif
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BYTE,
    SHIFT
  } state_t;

  state_t     state;
  state_t     state_next;

  // Bits of the current byte still to be sent after the one on prog_in.
  logic [6:0] shreg;
  // Position within the byte of the bit currently on prog_in (0 = bit 7).
  logic [2:0] bit_idx;

  logic       launch;
  logic       accept;
  logic       last_bit;
  logic       byte_end;

  logic       prog_en_d;
  logic       prog_in_d;
  logic       busy_d;
  logic       done_d;

  assign launch   = (state == IDLE) && start;
  assign accept   = (state == WAIT_BYTE) && byte_valid;
  assign last_bit = (state == SHIFT) && (bit_count == LAST_IDX);
  assign byte_end = (state == SHIFT) && (bit_idx == 3'd7);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; chain length termination takes priority over byte end
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = WAIT_BYTE;
      end
      WAIT_BYTE: begin
        if (byte_valid) state_next = SHIFT;
      end
      SHIFT: begin
        if (last_bit)      state_next = IDLE;
        else if (byte_end) state_next = WAIT_BYTE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode: byte_ready is direct from state, the rest are next values
  // for the output registers so every pin toggles only on rising clk.
  always_comb begin
    byte_ready = (state == WAIT_BYTE);
    prog_en_d  = (state_next == SHIFT);
    prog_in_d  = 1'b0;
    if (accept) begin
      prog_in_d = byte_data[7];
    end else if (state_next == SHIFT) begin
      prog_in_d = shreg[6];
    end
    busy_d = (state_next != IDLE);
    done_d = last_bit;
  end

  // Output registers, bit counter and byte shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prog_en   <= 1'b0;
      prog_in   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_count <= '0;
      shreg     <= '0;
      bit_idx   <= '0;
    end else begin
      prog_en <= prog_en_d;
      prog_in <= prog_in_d;
      busy    <= busy_d;
      done    <= done_d;

      if (launch) begin
        bit_count <= '0;
      end else if (state == SHIFT) begin
        bit_count <= bit_count + 1'b1;
      end

      if (accept) begin
        shreg   <= byte_data[6:0];
        bit_idx <= '0;
      end else if (state == SHIFT) begin
        shreg   <= {shreg[5:0], 1'b0};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

`ifdef TINYFPGA_CFG_READBACK_EN
  logic [15:0] crc_step;

  // One MSB-first CRC-16-CCITT step on the bit leaving the chain
  always_comb begin
    crc_step = {rb_crc[14:0], 1'b0} ^ ((rb_crc[15] ^ prog_out) ? 16'h1021 : 16'h0000);
  end

  // Readback CRC: reseeded on each accepted start, advanced on shift cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_crc <= 16'hFFFF;
    end else if (launch) begin
      rb_crc <= 16'hFFFF;
    end else if (prog_en) begin
      rb_crc <= crc_step;
    end
  end
`else
  logic unused_prog_out;
  assign unused_prog_out = prog_out;
`endif

endmodule

// File: doc/tinyfpga_cfg_loader.md
Name: tinyfpga_cfg_loader

Overview:
Host-side writer for the tinyFPGA configuration scan chain. It accepts a configuration bitstream as a byte stream over a valid/ready handshake and serializes it onto the chain's prog_in, with prog_en asserted, for exactly CHAIN_LEN bits. It sits between a host or ROM byte source and the chip's prog_en/prog_in/prog_out pins. It drives the chain in the same clock domain that clocks the chain.

Parameters:
CHAIN_LEN, 144, total configuration bits in the scan chain (>=1).
CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter and bit_count.

Ports:
clk  input  1  single clock; the chain samples prog_in on rising clk while prog_en=1
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a load; ignored unless idle
byte_data  input  8  bitstream byte
byte_valid  input  1  byte_data valid
byte_ready  output  1  loader accepts byte this cycle
prog_en  output  1  chain shift enable
prog_in  output  1  serial config bit to chain
prog_out  input  1  chain serial output (old contents), used only by the optional feature
busy  output  1  load in progress
done  output  1  one-cycle pulse when the last bit has been shifted
bit_count  output  CNT_W  bits shifted so far in the current load

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - prog_en=0, prog_in=0, byte_ready=0, busy=0, done=0, bit_count=0.
  - Shift register cleared.
- All outputs are registered. prog_en/prog_in change only on rising clk.
- States: IDLE, WAIT_BYTE, SHIFT.
- IDLE:
  - On start=1: go to WAIT_BYTE; bit_count<=0; busy<=1.
- WAIT_BYTE:
  - byte_ready=1 (combinational from state), prog_en=0 so the chain holds.
  - On byte_valid & byte_ready: latch byte_data; bit_idx<=0; go to SHIFT.
- SHIFT:
  - Each cycle: prog_en=1 and prog_in=current bit. Bits are sent MSB first (bit 7 first).
  - bit_count increments on every cycle with prog_en=1.
  - After bit 0 of the byte is sent, go to WAIT_BYTE if bit_count < CHAIN_LEN.
- Throughput: a byte is accepted in cycle N. Its bits appear on prog_in with prog_en=1 in cycles N+1..N+8. byte_ready is high again in cycle N+9, so the minimum cost is 9 cycles per byte.
- Termination:
  - When bit_count reaches CHAIN_LEN, the current byte is abandoned mid-way. If CHAIN_LEN mod 8 != 0, the low-order bits of the final byte are discarded.
  - In the cycle after the last shifted bit: prog_en=0, done=1 for one cycle, busy=0, state=IDLE.
  - bit_count holds CHAIN_LEN until the next start.
- Stalls: byte_valid may be low indefinitely in WAIT_BYTE. prog_en stays 0 throughout, and no bit is lost or duplicated.
- start is ignored while busy.
- byte_valid is ignored outside WAIT_BYTE.
- Reset mid-load returns immediately to the reset state. The chain holds a partial shift, and software must restart the load.
- prog_in is 0 whenever prog_en=0.

Optional Feature:
Macro TINYFPGA_CFG_READBACK_EN.
- Defined:
  - Adds output rb_crc[15:0].
  - rb_crc is CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first, no final XOR), computed over prog_out sampled on every rising clk where prog_en=1. This captures the previous configuration as it exits the chain.
  - rb_crc resets to 0xFFFF on rst and on an accepted start.
  - rb_crc is final in the done cycle and holds until the next start.
- Not defined: no rb_crc port and no CRC logic; prog_out is unused.

Test Plan:
- CHAIN_LEN=16; start; bytes 0xA5 and 0x3C offered continuously -> prog_in during prog_en=1 is 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0. Exactly 16 prog_en cycles, done pulses once, bit_count=16.
- CHAIN_LEN=12; bytes 0xFF, 0x80 -> 12 prog_en cycles. Last 4 bits are 1,0,0,0; the remaining bits of 0x80 are not shifted; the third byte is never accepted (byte_ready stays 0 after done).
- byte_valid withheld for 20 cycles between two bytes -> prog_en=0 and bit_count frozen for the whole gap. Output sequence is identical to the no-stall case.
- rst asserted during bit 5 of the second byte -> all outputs are 0 in the same cycle with no clock edge needed. A new start and full reload then complete normally.
- start pulsed again mid-load -> ignored; bit_count continues without reset and only one done pulse is seen.
- TINYFPGA_CFG_READBACK_EN, CHAIN_LEN=16, prog_out driven 0x0000 during the shift -> rb_crc equals the reference-model CRC of sixteen 0 bits at done. Check that the value matches the bench model computed from the stated polynomial, init and bit order.
